// File: rtl/multicycle_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_alu: registered ALU with carry chaining and a 1-bit/clk shifter |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_alu #(
  parameter int N = 8,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         use_c,
  input  logic [2:0]   ctrl,
  output logic [N-1:0] f,
  output logic         cout,
  output logic         v,
  output logic         z,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] C_OP_ADD   = 3'b000;
  localparam logic [2:0] C_OP_SHIFT = 3'b100;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sh_q, sh_d;
  logic [M-1:0]   cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic [N-1:0]   f_q, f_d;
  logic           cout_q, cout_d;
  logic           v_q, v_d;
  logic           z_q, z_d;
  logic           done_q, done_d;

  logic [M-1:0]   k;
  logic [N-1:0]   b_eff;
  logic           carry_in;
  logic [N:0]     sum;
  logic           carry_msb_in;
  logic [N-1:0]   res_f;
  logic           res_c;
  logic           res_v;
  logic [N-1:0]   sh_next;
  logic           sh_out;

  assign k = b[M-1:0];

  // The adder carry-in comes from the stored flag for ADC/SBC chaining.
  always_comb begin
    b_eff        = cin ? ~b : b;
    carry_in     = use_c ? cout_q : cin;
    sum          = {1'b0, a} + {1'b0, b_eff} + (N+1)'(carry_in);
    carry_msb_in = a[N-1] ^ b_eff[N-1] ^ sum[N-1];
  end

  always_comb begin
    res_f = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (ctrl)
      C_OP_ADD: begin
        res_f = sum[N-1:0];
        res_c = sum[N];
        res_v = carry_msb_in ^ sum[N];
      end
      3'b001, 3'b101: res_f = cin ? (a | ~b) : (a | b);
      3'b010, 3'b110: res_f = cin ? (a & ~b) : (a & b);
      3'b011:         res_f = cin ? ~b : ~a;
      C_OP_SHIFT:     res_f = a;
      default:        res_f = cin ? b : a;
    endcase
  end

  always_comb begin
    if (dir_q) begin
      sh_next = {1'b0, sh_q[N-1:1]};
      sh_out  = sh_q[0];
    end else begin
      sh_next = {sh_q[N-2:0], 1'b0};
      sh_out  = sh_q[N-1];
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    f_d     = f_q;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (ctrl == C_OP_SHIFT && k != '0) begin
            sh_d    = a;
            cnt_d   = k;
            dir_d   = cin;
            state_d = SHIFT;
          end else begin
            f_d    = res_f;
            cout_d = res_c;
            v_d    = res_v;
            z_d    = (res_f == '0);
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - M'(1);
        if (cnt_q == M'(1)) begin
          f_d     = sh_next;
          cout_d  = sh_out;
          v_d     = 1'b0;
          z_d     = (sh_next == '0);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
      done_q  <= done_d;
    end
  end

  assign f    = f_q;
  assign cout = cout_q;
  assign v    = v_q;
  assign z    = z_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_alu: scoreboard bench with an arithmetic reference model     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin, use_c;
  logic [2:0] ctrl;
  logic [7:0] f;
  logic       cout, v, z, busy, done;

  typedef struct packed {
    logic [7:0] f;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic mc;
  int   checks = 0;
  int   errors = 0;

  multicycle_alu #(.N(8), .M(3)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .use_c(use_c), .ctrl(ctrl), .f(f), .cout(cout), .v(v), .z(z),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic ic, input logic iu, input logic [2:0] ictl);
    exp_t e;
    int ai, bi, ci, s, sa, sb, ss, k, t;
    ai = int'(ia);
    k  = int'(ib[2:0]);
    e  = '0;
    case (ictl)
      3'd0: begin
        bi  = ic ? 255 - int'(ib) : int'(ib);
        ci  = iu ? int'(mc) : int'(ic);
        s   = ai + bi + ci;
        e.f = 8'(s % 256);
        e.c = (s > 255);
        sa  = (ai > 127) ? ai - 256 : ai;
        sb  = (bi > 127) ? bi - 256 : bi;
        ss  = sa + sb + ci;
        e.v = (ss > 127) || (ss < -128);
      end
      3'd1, 3'd5: e.f = ic ? (ia | ~ib) : (ia | ib);
      3'd2, 3'd6: e.f = ic ? (ia & ~ib) : (ia & ib);
      3'd3:       e.f = ic ? ~ib : ~ia;
      3'd4: begin
        if (!ic) begin
          t   = ai << k;
          e.f = 8'(t % 256);
          e.c = (k != 0) && (((t >> 8) & 1) == 1);
        end else begin
          e.f = 8'(ai >> k);
          e.c = (k != 0) && (((ai >> (k - 1)) & 1) == 1);
        end
      end
      default:    e.f = ic ? ib : ia;
    endcase
    e.z = (e.f == 8'h00);
    return e;
  endfunction

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ic, input logic iu, input logic [2:0] ictl);
    exp_t e;
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("issue_wait_busy", int'(busy), 0);
    a = ia; b = ib; cin = ic; use_c = iu; ctrl = ictl; start = 1'b1;
    e = model(ia, ib, ic, iu, ictl);
    mc = e.c;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic expect_out(input string nm, input logic [7:0] ef,
                            input logic ec, input logic ev, input logic ez);
    chk({nm, "_f"}, int'(f), int'(ef));
    chk({nm, "_cout"}, int'(cout), int'(ec));
    chk({nm, "_v"}, int'(v), int'(ev));
    chk({nm, "_z"}, int'(z), int'(ez));
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", int'(done), 0);
      end else begin
        mon_e = q.pop_front();
        chk("mon_f", int'(f), int'(mon_e.f));
        chk("mon_cout", int'(cout), int'(mon_e.c));
        chk("mon_v", int'(v), int'(mon_e.v));
        chk("mon_z", int'(z), int'(mon_e.z));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; use_c = 1'b0; ctrl = '0;
    mc = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(8'h7F, 8'h01, 1'b0, 1'b0, 3'b000);
    drain();
    expect_out("add_ovf", 8'h80, 1'b0, 1'b1, 1'b0);

    issue(8'h05, 8'h05, 1'b1, 1'b0, 3'b000);
    drain();
    expect_out("sub_zero", 8'h00, 1'b1, 1'b0, 1'b1);
    issue(8'h55, 8'h3C, 1'b1, 1'b0, 3'b111);
    drain();
    expect_out("pass_b", 8'h3C, 1'b0, 1'b0, 1'b0);

    issue(8'hFF, 8'h01, 1'b0, 1'b0, 3'b000);
    issue(8'h00, 8'h00, 1'b0, 1'b1, 3'b000);
    issue(8'h10, 8'h01, 1'b1, 1'b1, 3'b000);
    drain();
    expect_out("sbc", 8'h0E, 1'b1, 1'b0, 1'b0);

    issue(8'h81, 8'h03, 1'b0, 1'b0, 3'b100);
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lsl3_busy_cycles", n, 3);
    chk("lsl3_done_after_busy", int'(done), 1);
    drain();
    expect_out("lsl3", 8'h08, 1'b0, 1'b0, 1'b0);

    issue(8'h81, 8'h01, 1'b1, 1'b0, 3'b100);
    drain();
    expect_out("lsr1", 8'h40, 1'b1, 1'b0, 1'b0);

    issue(8'h81, 8'h00, 1'b0, 1'b0, 3'b100);
    chk("lsl0_busy", int'(busy), 0);
    chk("lsl0_done", int'(done), 1);
    drain();
    expect_out("lsl0", 8'h81, 1'b0, 1'b0, 1'b0);

    issue(8'hF0, 8'h07, 1'b0, 1'b0, 3'b100);
    repeat (2) @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; ctrl = 3'b000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    expect_out("lsl7_ignored_start", 8'h00, 1'b0, 1'b0, 1'b1);

    issue(8'h81, 8'h05, 1'b0, 1'b0, 3'b100);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    mc = 1'b0;
    expect_out("abort", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (6) @(negedge clk);
    issue(8'h03, 8'h04, 1'b0, 1'b0, 3'b000);
    drain();
    expect_out("after_abort", 8'h07, 1'b0, 1'b0, 1'b0);

    repeat (80) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Registered, parametrised successor to the combinational n-bit ALU bitslice datapath. It keeps the same ctrl/cin function table.
- Additions:
  - registered result and flags;
  - start/busy/done handshake;
  - iterative shifter that moves one bit per clock;
  - add/subtract with carry from the stored carry flag, for multi-word arithmetic.
- Sits between the register file and writeback in the processor datapath. The controller stalls on busy.

Parameters:
- n, 8, data width in bits.
- m, 3, shift-count width; shift amount is b[m-1:0]. Required: 2^m <= n.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- a  input  n  operand A; sampled on the accepting edge.
- b  input  n  operand B / shift amount; sampled on the accepting edge.
- cin  input  1  function select / invert-B; sampled on the accepting edge.
- use_c  input  1  1 = adder carry-in taken from the stored cout flag; sampled on the accepting edge.
- ctrl  input  3  function select; sampled on the accepting edge.
- f  output  n  registered result.
- cout  output  1  registered carry flag.
- v  output  1  registered overflow flag.
- z  output  1  registered zero flag, 1 when f=0.
- busy  output  1  high while an iterative shift is in progress.
- done  output  1  one-cycle pulse in the cycle after f and flags are loaded.

Behaviour:
- Reset (rst=1 at an edge):
  - f=0, cout=0, v=0, z=0, busy=0, done=0, state=IDLE, shift counter=0.
  - Overrides start.
  - Reset during SHIFT aborts the operation: no done, partial result discarded.
- Function table (ctrl cin):
  - 000 0: A+B
  - 000 1: A-B (A+~B+1)
  - 001/101 0: A|B; 001/101 1: A|~B
  - 010/110 0: A&B; 010/110 1: A&~B
  - 011 0: ~A; 011 1: ~B
  - 100 0: LSL A by k; 100 1: LSR A by k
  - 111 0: A; 111 1: B
  - k = b[m-1:0], unsigned.
- Adder carry-in:
  - use_c=0: carry-in = cin.
  - use_c=1: carry-in = stored cout, and B is still inverted when cin=1.
  - This gives ADC (cin=0) and SBC (cin=1; carry=1 means no borrow).
  - use_c is ignored for all ctrl other than 000.
- States are IDLE and SHIFT.
- IDLE with start=1:
  - Shift op (ctrl=100) with k!=0: load shift register with a, counter with k; go to SHIFT; busy=1 from the next cycle. f and flags are not updated yet.
  - Any other op, or a shift with k=0: at this edge f <= result and flags update; done=1 in the following cycle; stay in IDLE. Latency is 1 clock.
- SHIFT, each edge:
  - Shift by one bit, zero fill; record the bit shifted out; decrement counter.
  - On the edge where the counter reaches 0: f <= final value, flags update, done=1 next cycle, busy=0, go to IDLE.
  - Shift latency is k clocks from the accepting edge.
- start while busy=1 is ignored (not queued).
- start in the same cycle as done=1 is accepted, so back-to-back ops are allowed.
- Flags:
  - z = (new f == 0) for every op.
  - cout:
    - ctrl=000: adder carry-out from bit n-1.
    - Shift: last bit shifted out; 0 when k=0.
    - Other ops: 0.
  - v:
    - ctrl=000: carry[n-1] XOR carry[n] (signed overflow).
    - Other ops: 0.
- f and flags hold their values between operations. done is low except for the single pulse.
- Width rules: all arithmetic is modulo 2^n; no sign extension; shifts are logical.

Test Plan (n=8, m=3):
1. Reset, then add a=0x7F b=0x01 ctrl=000 cin=0 use_c=0 -> after 1 edge: f=0x80, v=1, cout=0, z=0, done pulses once.
2. Subtract a=0x05 b=0x05 ctrl=000 cin=1 -> f=0x00, z=1, cout=1, v=0. Then ctrl=111 cin=1 b=0x3C -> f=0x3C, cout=0, z=0.
3. Multi-word add:
   - 0xFF+0x01 use_c=0 -> f=0x00, cout=1.
   - Back-to-back ADC a=0x00 b=0x00 cin=0 use_c=1 -> f=0x01, cout=0.
   - SBC with stored cout=0: a=0x10 b=0x01 cin=1 use_c=1 -> f=0x0E.
4. Shifts:
   - LSL a=0x81 b=0x03 -> busy high 3 cycles, f=0x08, cout=0, done on cycle 4.
   - LSR a=0x81 b=0x01 -> f=0x40, cout=1.
   - LSL b=0x00 -> 1-cycle latency, f=0x81, cout=0.
5. Shift a=0xF0 b=0x07; pulse start with other operands mid-shift -> request ignored, f=0x00 (LSL) and z=1 after 7 cycles.
6. Assert rst during a 5-cycle shift -> next cycle busy=0, f=0, flags 0, no done pulse. A subsequent op completes normally.
